// File: rtl/load_store_unit.sv
// load_store_unit: sequences one RV32I load or store at a time onto a stalling data memory.
// A request is checked for legality, issued as a single strobe, and then the unit follows the
// memory's busy pulse (rise, then fall) before returning a one-cycle response.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitHi,
    StWaitLo,
    StResp
  } state_e;

  state_e      state_q;
  logic        we_q;
  logic [4:0]  cnt_q;
  logic [3:0]  req_mask;
  logic        req_bad;
  logic        cnt_last;

  // Last permitted cycle in a wait phase; leaving on this cycle without progress is a timeout.
  assign cnt_last = (cnt_q == 5'(TIMEOUT - 1));

  // Decode the incoming request into the memory size/sign mask and a legality flag.
  always_comb begin
    req_mask = 4'b0000;
    req_bad  = 1'b0;
    if (req_we) begin
      case (req_funct3)
        3'b000:  req_mask = 4'b0001;
        3'b001:  req_mask = 4'b0011;
        3'b010:  req_mask = 4'b0111;
        default: req_bad  = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'b000:  req_mask = 4'b1001;
        3'b001:  req_mask = 4'b1011;
        3'b010:  req_mask = 4'b1111;
        3'b100:  req_mask = 4'b0001;
        3'b101:  req_mask = 4'b0011;
        default: req_bad  = 1'b1;
      endcase
    end
    // funct3[1:0] carries the access size for both loads and stores.
    if (req_funct3[1:0] == 2'b01 && req_addr[0]) begin
      req_bad = 1'b1;
    end
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) begin
      req_bad = 1'b1;
    end
  end

  // Control FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      we_q           <= 1'b0;
      cnt_q          <= 5'd0;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_rdata     <= 32'd0;
      mem_addr       <= 32'd0;
      mem_write_data <= 32'd0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      mem_sign_mask  <= 4'b0000;
    end else begin
      // Pulses default low; only the transitions below raise them.
      resp_valid   <= 1'b0;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q           <= req_we;
            mem_addr       <= req_addr;
            mem_write_data <= req_we ? req_wdata : 32'd0;
            mem_sign_mask  <= req_bad ? 4'b0000 : req_mask;
            req_ready      <= 1'b0;
            if (req_bad) begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              state_q      <= StIssue;
              mem_memread  <= ~req_we;
              mem_memwrite <= req_we;
            end
          end
        end
        StIssue: begin
          state_q <= StWaitHi;
          cnt_q   <= 5'd0;
        end
        StWaitHi: begin
          if (mem_clk_stall) begin
            state_q <= StWaitLo;
            cnt_q   <= 5'd0;
          end else if (cnt_last) begin
            state_q    <= StResp;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        StWaitLo: begin
          if (!mem_clk_stall) begin
            state_q    <= StResp;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= we_q ? 32'd0 : mem_read_data;
          end else if (cnt_last) begin
            state_q    <= StResp;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        StResp: begin
          state_q    <= StIdle;
          req_ready  <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end
        default: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed requests against a timeline model of each transaction.
// The model predicts, per request, the strobe cycle and the response cycle from the memory's
// stall delay/length; a compare process checks every output on every cycle against it.
module tb_load_store_unit;

  localparam int unsigned TO    = 16;
  localparam int unsigned NEVER = 100000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;
  logic        mem_clk_stall;

  int unsigned cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;

  // Transaction model: accept cycle, response cycle and expected response contents.
  bit          m_have = 1'b0;
  int unsigned m_a = 0;
  int unsigned m_r = 0;
  bit          m_derr = 1'b0;
  bit          m_we = 1'b0;
  bit          m_err = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_wdata = 32'd0;
  logic [31:0] m_rdata = 32'd0;
  logic [3:0]  m_mask = 4'd0;

  // Memory behaviour: stall rises mem_d cycles after the strobe and stays high mem_l cycles.
  int unsigned mem_d = 1;
  int unsigned mem_l = 1;
  int unsigned stall_on = 0;
  int unsigned stall_off = 0;

  load_store_unit #(
    .TIMEOUT(TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .mem_addr      (mem_addr),
    .mem_write_data(mem_write_data),
    .mem_memread   (mem_memread),
    .mem_memwrite  (mem_memwrite),
    .mem_sign_mask (mem_sign_mask),
    .mem_read_data (mem_read_data),
    .mem_clk_stall (mem_clk_stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cycle(input int unsigned n);
    while (cyc < n) next_cycle();
  endtask

  task automatic sample_at(input int unsigned n);
    goto_cycle(n);
    @(negedge clk);
  endtask

  function automatic logic [3:0] exp_mask(input logic we, input logic [2:0] f3);
    logic [3:0] m;
    m = 4'b0000;
    if (we) begin
      case (f3)
        3'b000:  m = 4'b0001;
        3'b001:  m = 4'b0011;
        3'b010:  m = 4'b0111;
        default: m = 4'b0000;
      endcase
    end else begin
      case (f3)
        3'b000:  m = 4'b1001;
        3'b001:  m = 4'b1011;
        3'b010:  m = 4'b1111;
        3'b100:  m = 4'b0001;
        3'b101:  m = 4'b0011;
        default: m = 4'b0000;
      endcase
    end
    return m;
  endfunction

  function automatic bit model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    bit legal;
    int unsigned size_bytes;
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) return 1'b1;
    size_bytes = 1 << f3[1:0];
    return (addr % size_bytes) != 0;
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_memread"}, 32'(mem_memread), 32'd0);
    chk({tag, "_memwrite"}, 32'(mem_memwrite), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_write_data, 32'd0);
    chk({tag, "_mask"}, 32'(mem_sign_mask), 32'd0);
  endtask

  // Present one request; with early=1 it is already presented during the previous RESP cycle.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int unsigned d, input int unsigned l, input bit early);
    int unsigned s;
    int unsigned lo;
    if (early) goto_cycle(m_r);
    else goto_cycle(m_r + 1);
    req_valid     = 1'b1;
    req_we        = we;
    req_funct3    = f3;
    req_addr      = addr;
    req_wdata     = wdata;
    mem_read_data = rdata;
    mem_d         = d;
    mem_l         = l;
    if (early) next_cycle();
    m_a     = cyc;
    m_we    = we;
    m_addr  = addr;
    m_wdata = wdata;
    m_mask  = exp_mask(we, f3);
    m_derr  = model_err(we, f3, addr);
    s       = m_a + 1;
    if (m_derr) begin
      m_r = m_a + 1; m_err = 1'b1; m_rdata = 32'd0;
    end else if (d > TO) begin
      m_r = s + 1 + TO; m_err = 1'b1; m_rdata = 32'd0;
    end else begin
      lo = s + d + 1;
      if (l > TO) begin
        m_r = lo + TO; m_err = 1'b1; m_rdata = 32'd0;
      end else begin
        m_r = s + d + l + 1; m_err = 1'b0; m_rdata = we ? 32'd0 : rdata;
      end
    end
    m_have = 1'b1;
    next_cycle();
    req_valid = 1'b0;
  endtask

  // Memory responder.
  initial begin
    mem_clk_stall = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mem_clk_stall = (cyc >= stall_on) && (cyc < stall_off);
      @(negedge clk);
      if (mem_memread || mem_memwrite) begin
        stall_on  = cyc + mem_d;
        stall_off = cyc + mem_d + mem_l;
      end
    end
  end

  // Per-cycle comparison against the transaction model.
  initial begin
    bit busy;
    bit rv_exp;
    forever begin
      @(negedge clk);
      busy   = m_have && cyc > m_a && cyc <= m_r;
      rv_exp = m_have && cyc == m_r;
      chk("req_ready", 32'(req_ready), 32'(!busy));
      chk("memread", 32'(mem_memread), 32'(m_have && !m_derr && !m_we && cyc == m_a + 1));
      chk("memwrite", 32'(mem_memwrite), 32'(m_have && !m_derr && m_we && cyc == m_a + 1));
      chk("resp_valid", 32'(resp_valid), 32'(rv_exp));
      if (rv_exp) begin
        chk("resp_err", 32'(resp_err), 32'(m_err));
        chk("resp_rdata", resp_rdata, m_rdata);
      end
      if (m_have && !m_derr && cyc > m_a && cyc < m_r) begin
        chk("mem_addr_hold", mem_addr, m_addr);
        chk("mask_hold", 32'(mem_sign_mask), 32'(m_mask));
        if (m_we) chk("wdata_hold", mem_write_data, m_wdata);
      end
    end
  end

  initial begin
    reset         = 1'b1;
    req_valid     = 1'b0;
    req_we        = 1'b0;
    req_funct3    = 3'd0;
    req_addr      = 32'd0;
    req_wdata     = 32'd0;
    mem_read_data = 32'd0;
    repeat (2) next_cycle();
    check_reset_values("rst");
    reset = 1'b0;
    m_r   = cyc;

    // LW with a three-cycle stall: six-cycle latency.
    run_txn(1'b0, 3'b010, 32'h1004, 32'h0, 32'hDEADBEEF, 1, 3, 1'b0);
    sample_at(m_a + 1);
    chk("lw_memread", 32'(mem_memread), 32'd1);
    chk("lw_mask", 32'(mem_sign_mask), 32'b1111);
    sample_at(m_a + 6);
    chk("lw_resp_valid", 32'(resp_valid), 32'd1);
    chk("lw_rdata", resp_rdata, 32'hDEADBEEF);
    chk("lw_err", 32'(resp_err), 32'd0);

    // SB: write data held through the last stalled cycle.
    run_txn(1'b1, 3'b000, 32'h1003, 32'h000000A5, 32'h12345678, 1, 3, 1'b0);
    sample_at(m_a + 1);
    chk("sb_memwrite", 32'(mem_memwrite), 32'd1);
    chk("sb_mask", 32'(mem_sign_mask), 32'b0001);
    sample_at(m_a + 5);
    chk("sb_wdata_late", mem_write_data, 32'h000000A5);
    sample_at(m_a + 6);
    chk("sb_resp_valid", 32'(resp_valid), 32'd1);
    chk("sb_rdata", resp_rdata, 32'd0);

    // Misaligned halfword and word loads: immediate error, no strobe.
    run_txn(1'b0, 3'b001, 32'h1001, 32'h0, 32'hFFFF1234, 1, 3, 1'b0);
    sample_at(m_a + 1);
    chk("lh_mis_valid", 32'(resp_valid), 32'd1);
    chk("lh_mis_err", 32'(resp_err), 32'd1);
    chk("lh_mis_memread", 32'(mem_memread), 32'd0);
    run_txn(1'b0, 3'b010, 32'h1002, 32'h0, 32'hFFFF1234, 1, 3, 1'b0);
    sample_at(m_a + 1);
    chk("lw_mis_valid", 32'(resp_valid), 32'd1);
    chk("lw_mis_err", 32'(resp_err), 32'd1);

    // Stall never rises: timeout out of WAIT_HI.
    run_txn(1'b0, 3'b010, 32'h1008, 32'h0, 32'hCAFEF00D, NEVER, 1, 1'b0);
    sample_at(m_a + 17);
    chk("to_hi_early", 32'(resp_valid), 32'd0);
    sample_at(m_a + 18);
    chk("to_hi_valid", 32'(resp_valid), 32'd1);
    chk("to_hi_err", 32'(resp_err), 32'd1);
    chk("to_hi_rdata", resp_rdata, 32'd0);

    // Stall never falls: timeout out of WAIT_LO.
    run_txn(1'b0, 3'b010, 32'h100C, 32'h0, 32'hCAFEF00D, 1, NEVER, 1'b0);
    sample_at(m_a + 19);
    chk("to_lo_valid", 32'(resp_valid), 32'd1);
    chk("to_lo_err", 32'(resp_err), 32'd1);

    // Assorted legal and illegal requests.
    run_txn(1'b0, 3'b000, 32'h1001, 32'h0, 32'hFFFFFF80, 2, 1, 1'b0);
    run_txn(1'b0, 3'b011, 32'h1000, 32'h0, 32'h1, 1, 1, 1'b0);
    run_txn(1'b0, 3'b110, 32'h1000, 32'h0, 32'h1, 1, 1, 1'b0);
    run_txn(1'b1, 3'b011, 32'h1000, 32'h5, 32'h1, 1, 1, 1'b0);
    run_txn(1'b1, 3'b001, 32'h2001, 32'hBEEF, 32'h1, 1, 1, 1'b0);
    run_txn(1'b1, 3'b001, 32'h2002, 32'hBEEF, 32'h1, 3, 2, 1'b0);
    run_txn(1'b1, 3'b010, 32'h2000, 32'h00000001, 32'h1, 1, 1, 1'b0);
    // Presented during RESP: must only be taken once the unit is back in IDLE.
    run_txn(1'b0, 3'b101, 32'h2002, 32'h0, 32'h0000F00D, 1, 4, 1'b1);
    // Progress on the last allowed cycle of each wait phase, then one cycle too late.
    run_txn(1'b0, 3'b010, 32'h3000, 32'h0, 32'h0BADC0DE, 16, 16, 1'b0);
    run_txn(1'b0, 3'b010, 32'h3004, 32'h0, 32'h0BADC0DE, 17, 1, 1'b0);
    run_txn(1'b0, 3'b010, 32'h3008, 32'h0, 32'h0BADC0DE, 1, 17, 1'b0);

    // Reset in WAIT_LO: immediate reset values, the access is dropped.
    run_txn(1'b0, 3'b010, 32'h1010, 32'h0, 32'h11111111, 1, 10, 1'b0);
    goto_cycle(m_a + 4);
    #2;
    reset  = 1'b1;
    m_have = 1'b0;
    #1;
    check_reset_values("rst_wait_lo");
    next_cycle();
    reset = 1'b0;
    m_r   = cyc;

    run_txn(1'b0, 3'b100, 32'h1005, 32'h0, 32'h000000C3, 1, 2, 1'b0);
    sample_at(m_a + 1);
    chk("lbu_mask", 32'(mem_sign_mask), 32'b0001);
    chk("lbu_memread", 32'(mem_memread), 32'd1);
    sample_at(m_a + 5);
    chk("lbu_valid", 32'(resp_valid), 32'd1);
    chk("lbu_rdata", resp_rdata, 32'h000000C3);

    goto_cycle(m_r + 2);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, giving the max cycles spent waiting in either stall phase before aborting.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1: pipeline request present.
REQ-005 SHALL have port req_ready, output, 1: unit can accept a request this cycle.
REQ-006 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3: RV32I load/store funct3.
REQ-008 SHALL have port req_addr, input, 32: byte address.
REQ-009 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-010 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32: load result; 0 for stores and errors.
REQ-012 SHALL have port resp_err, output, 1: misaligned, illegal funct3, or timeout; qualified by resp_valid.
REQ-013 SHALL have port mem_addr, output, 32: address to data memory.
REQ-014 SHALL have port mem_write_data, output, 32: write data to data memory.
REQ-015 SHALL have port mem_memread, output, 1: read strobe.
REQ-016 SHALL have port mem_memwrite, output, 1: write strobe.
REQ-017 SHALL have port mem_sign_mask, output, 4: {signed, size mask}.
REQ-018 SHALL have port mem_read_data, input, 32: memory read result, already extended by the memory.
REQ-019 SHALL have port mem_clk_stall, input, 1: memory busy indicator.

Function
REQ-020 SHALL implement states IDLE, ISSUE, WAIT_HI, WAIT_LO, RESP; req_ready=1 only in IDLE.
REQ-021 SHALL, in IDLE with req_valid=1, latch we/funct3/addr/wdata in that cycle and leave IDLE on the next edge.
REQ-022 SHALL encode mem_sign_mask as: LB 1001, LH 1011, LW 1111, LBU 0001, LHU 0011, SB 0001, SH 0011, SW 0111.
REQ-023 SHALL treat as errors: load funct3 011/110/111; store funct3 >010; halfword with addr[0]=1; word with addr[1:0]!=00. On error it SHALL go IDLE->RESP with resp_err=1 and issue no memory strobe.
REQ-024 SHALL, on a valid request, go IDLE->ISSUE, then assert exactly one of mem_memread/mem_memwrite for exactly one cycle (ISSUE), then go to WAIT_HI.
REQ-025 SHALL hold mem_addr, mem_write_data and mem_sign_mask stable from ISSUE until leaving WAIT_LO.
REQ-026 SHALL keep mem_memread and mem_memwrite at 0 in every state except ISSUE.
REQ-027 SHALL, in WAIT_HI, move to WAIT_LO on mem_clk_stall=1; in WAIT_LO, move to RESP on mem_clk_stall=0.
REQ-028 SHALL, for loads, capture mem_read_data into resp_rdata on the edge leaving WAIT_LO.
REQ-029 SHALL use a 5-bit cycle counter cleared on entry to WAIT_HI and WAIT_LO; if it reaches TIMEOUT in either state, it SHALL go to RESP with resp_err=1 and resp_rdata=0.
REQ-030 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE; a new request SHALL NOT be accepted in RESP.
REQ-031 SHALL not interpret address ranges; 0x2000 LED writes are ordinary stores.
REQ-032 Minimum latency, IDLE accept to resp_valid, for a memory stalling 3 cycles SHALL be 6 cycles; error responses SHALL take 1 cycle.

Reset
REQ-033 SHALL, while reset=1, immediately force state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem strobes=0, mem_addr=0, mem_write_data=0, mem_sign_mask=0, counter=0.
REQ-034 SHALL abandon any in-flight access on reset without emitting resp_valid.

Verification
REQ-035 LW addr 0x1004, memory stalls 3 cycles and returns 0xDEADBEEF -> one memread pulse, sign_mask 1111, resp_valid once with rdata 0xDEADBEEF, err=0.
REQ-036 SB addr 0x1003, wdata 0x000000A5 -> one memwrite pulse, sign_mask 0001, mem_write_data 0xA5 held until stall falls, resp_valid with rdata 0, err=0.
REQ-037 LH addr 0x1001 -> no strobe, resp_valid next cycle with err=1; LW addr 0x1002 gives the same result.
REQ-038 LW with mem_clk_stall held at 0 -> resp_err=1 after TIMEOUT=16 cycles in WAIT_HI; stall held at 1 gives the same timeout from WAIT_LO.
REQ-039 reset asserted in WAIT_LO -> outputs take reset values asynchronously, no resp_valid; a following LBU returns sign_mask 0001 and completes normally.
